vc_arbiter_mux: RTL and testbench



---
 rtl/vc_pkg.sv | 21 ++
 rtl/vc_arbiter_mux_grant.sv | 42 ++++
 rtl/vc_arbiter_mux.sv | 113 +++++++++++
 tb/tb_vc_arbiter_mux.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared definitions for the VC arbiter/mux stage: FSM encoding and the
// default widths that must match the upstream VC FIFOs.
package vc_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSED = 2'd2
  } state_t;

  // Word width of the VC FIFOs feeding this stage.
  localparam int DATA_SIZE_DEF     = 6;
  // Data bit that steers a word to D0 (0) or D1 (1).
  localparam int DEST_BIT_DEF      = 5;
  // Consecutive VC0 grants allowed while VC1 is waiting.
  localparam int MAX_VC0_BURST_DEF = 4;
  // Width of the per-destination word counters.
  localparam int CNT_SIZE_DEF      = 8;

endpackage

// File: rtl/vc_arbiter_mux_grant.sv
// Grant logic between VC0 and VC1. VC0 wins by default, but after
// MAX_VC0_BURST back-to-back VC0 grants with VC1 waiting, VC1 gets one turn.
module rr_burst_grant
  import vc_pkg::*;
#(
  parameter int MAX_VC0_BURST = MAX_VC0_BURST_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_can_pop,
  input  logic i_empty_vc0,
  input  logic i_empty_vc1,
  output logic o_pop_vc0,
  output logic o_pop_vc1
);

  // Counter must hold the value MAX_VC0_BURST itself.
  localparam int CW = (MAX_VC0_BURST < 1) ? 1 : $clog2(MAX_VC0_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_VC0_BURST);

  logic [CW-1:0] r_burst_cnt;
  logic          w_sel_vc1;

  // Pick the source and qualify it; the two pops are mutually exclusive by construction.
  always_comb begin
    w_sel_vc1 = i_empty_vc0 | ((r_burst_cnt == BURST_MAX) & ~i_empty_vc1);
    o_pop_vc1 = i_can_pop & w_sel_vc1 & ~i_empty_vc1;
    o_pop_vc0 = i_can_pop & ~w_sel_vc1 & ~i_empty_vc0;
  end

  // Track VC0 streak length while VC1 waits; saturates at the burst limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (i_empty_vc1 || o_pop_vc1) begin
      r_burst_cnt <= '0;
    end else if (o_pop_vc0 && (r_burst_cnt != BURST_MAX)) begin
      r_burst_cnt <= r_burst_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vc_arbiter_mux.sv
// Pops one word per cycle from the granted VC FIFO and, one cycle later,
// pushes it into D0 or D1 depending on its destination bit. Popping halts
// on any destination pause since the destination is unknown until the read.
module vc_arbiter_mux
  import vc_pkg::*;
#(
  parameter int DATA_SIZE     = DATA_SIZE_DEF,
  parameter int DEST_BIT      = DEST_BIT_DEF,
  parameter int MAX_VC0_BURST = MAX_VC0_BURST_DEF,
  parameter int CNT_SIZE      = CNT_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_mux_0,
  input  logic [DATA_SIZE-1:0] data_mux_1,
  input  logic                 pause_d0,
  input  logic                 pause_d1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic                 idle,
  output logic [CNT_SIZE-1:0]  cnt_d0,
  output logic [CNT_SIZE-1:0]  cnt_d1
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_any_pause;
  logic                 w_any_data;
  logic                 w_can_pop;
  logic                 r_valid;
  logic                 r_src;
  logic [DATA_SIZE-1:0] w_word;
  logic [CNT_SIZE-1:0]  r_cnt_d0;
  logic [CNT_SIZE-1:0]  r_cnt_d1;

  assign w_any_pause = pause_d0 | pause_d1;
  assign w_any_data  = ~fifo_empty_vc0 | ~fifo_empty_vc1;
  assign w_can_pop   = (r_state == ACTIVE) & ~w_any_pause;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state: pause dominates, otherwise follow VC occupancy.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_any_data) w_state_next = w_any_pause ? PAUSED : ACTIVE;
      ACTIVE: begin
        if (w_any_pause)      w_state_next = PAUSED;
        else if (!w_any_data) w_state_next = IDLE;
      end
      PAUSED:  if (!w_any_pause) w_state_next = w_any_data ? ACTIVE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  rr_burst_grant #(
    .MAX_VC0_BURST (MAX_VC0_BURST)
  ) u_grant (
    .clk         (clk),
    .reset       (reset),
    .i_can_pop   (w_can_pop),
    .i_empty_vc0 (fifo_empty_vc0),
    .i_empty_vc1 (fifo_empty_vc1),
    .o_pop_vc0   (pop_vc0),
    .o_pop_vc1   (pop_vc1)
  );

  // Remember that a word is arriving next cycle and which FIFO it comes from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_src   <= 1'b0;
    end else begin
      r_valid <= pop_vc0 | pop_vc1;
      if (pop_vc0 || pop_vc1) r_src <= pop_vc1;
    end
  end

  // Steer the arriving word by its destination bit; outputs are zero when no word is present.
  always_comb begin
    w_word  = r_src ? data_mux_1 : data_mux_0;
    push_d0 = r_valid & ~w_word[DEST_BIT];
    push_d1 = r_valid &  w_word[DEST_BIT];
    data_d0 = r_valid ? w_word : '0;
    data_d1 = r_valid ? w_word : '0;
  end

  // Per-destination push counters, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_d0 <= '0;
      r_cnt_d1 <= '0;
    end else begin
      if (push_d0) r_cnt_d0 <= r_cnt_d0 + CNT_SIZE'(1);
      if (push_d1) r_cnt_d1 <= r_cnt_d1 + CNT_SIZE'(1);
    end
  end

  assign cnt_d0 = r_cnt_d0;
  assign cnt_d1 = r_cnt_d1;
  assign idle   = (r_state == IDLE) & ~r_valid;

endmodule

// File: tb/tb_vc_arbiter_mux.sv
// Randomized bench for vc_arbiter_mux: the VC FIFOs are queues in the bench,
// and a transaction-level model predicts pops, pushes, idle and counters.
module tb_vc_arbiter_mux;

  localparam int DW   = 6;
  localparam int DB   = 5;
  localparam int MAXB = 4;
  localparam int CW   = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty_vc0, fifo_empty_vc1;
  logic [DW-1:0] data_mux_0, data_mux_1;
  logic          pause_d0, pause_d1;
  logic          pop_vc0, pop_vc1, push_d0, push_d1, idle;
  logic [DW-1:0] data_d0, data_d1;
  logic [CW-1:0] cnt_d0, cnt_d1;

  always #5 clk = ~clk;

  vc_arbiter_mux dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty_vc0 (fifo_empty_vc0),
    .fifo_empty_vc1 (fifo_empty_vc1),
    .data_mux_0     (data_mux_0),
    .data_mux_1     (data_mux_1),
    .pause_d0       (pause_d0),
    .pause_d1       (pause_d1),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_d0        (data_d0),
    .data_d1        (data_d1),
    .idle           (idle),
    .cnt_d0         (cnt_d0),
    .cnt_d1         (cnt_d1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  typedef enum {M_IDLE, M_ACTIVE, M_PAUSED} mstate_t;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  mstate_t       m_st;
  int            m_streak;
  bit            m_busy;
  logic [DW-1:0] m_word;
  int            m_cnt0, m_cnt1;
  int            pause_pct;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_st     = M_IDLE;
    m_streak = 0;
    m_busy   = 1'b0;
    m_word   = '0;
    m_cnt0   = 0;
    m_cnt1   = 0;
    fifo_empty_vc0 = 1'b1;
    fifo_empty_vc1 = 1'b1;
    pause_d0 = 1'b0;
    pause_d1 = 1'b0;
  endtask

  // One clock: drive inputs, check at negedge, advance model after posedge.
  task automatic cycle();
    bit e0, e1, can, want1, x0, x1, pz;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    fifo_empty_vc0 = e0;
    fifo_empty_vc1 = e1;
    pause_d0 = ($urandom_range(99) < pause_pct);
    pause_d1 = ($urandom_range(99) < pause_pct);
    pz    = pause_d0 | pause_d1;
    can   = (m_st == M_ACTIVE) && !pz;
    want1 = !e1 && (e0 || m_streak >= MAXB);
    x1    = can && want1;
    x0    = can && !e0 && !want1;
    @(negedge clk);
    chk("pop_vc0", pop_vc0, x0);
    chk("pop_vc1", pop_vc1, x1);
    chk("pop_excl", pop_vc0 & pop_vc1, 0);
    chk("push_d0", push_d0, m_busy && !m_word[DB]);
    chk("push_d1", push_d1, m_busy && m_word[DB]);
    chk("data_d0", data_d0, m_busy ? m_word : 6'd0);
    chk("data_d1", data_d1, m_busy ? m_word : 6'd0);
    chk("idle", idle, (m_st == M_IDLE) && !m_busy);
    chk("cnt_d0", cnt_d0, m_cnt0 & 255);
    chk("cnt_d1", cnt_d1, m_cnt1 & 255);
    if (m_busy) $display("push D%0d word 0x%02h", m_word[DB], m_word);
    @(posedge clk);
    #1;
    if (m_busy) begin
      if (m_word[DB]) m_cnt1++;
      else            m_cnt0++;
    end
    m_busy = x0 || x1;
    if (x0) begin m_word = q0.pop_front(); data_mux_0 = m_word; end
    else          data_mux_0 = DW'($urandom);
    if (x1) begin m_word = q1.pop_front(); data_mux_1 = m_word; end
    else          data_mux_1 = DW'($urandom);
    if (e1 || x1)                   m_streak = 0;
    else if (x0 && m_streak < MAXB) m_streak++;
    case (m_st)
      M_IDLE:   if (!(e0 && e1)) m_st = pz ? M_PAUSED : M_ACTIVE;
      M_ACTIVE: if (pz) m_st = M_PAUSED; else if (e0 && e1) m_st = M_IDLE;
      M_PAUSED: if (!pz) m_st = (e0 && e1) ? M_IDLE : M_ACTIVE;
      default:  m_st = M_IDLE;
    endcase
  endtask

  // Assert reset between edges and check outputs clear without a clock.
  task automatic reset_mid(input string tag);
    chk({tag, "_pre_push"}, push_d0 | push_d1, m_busy);
    reset = 1'b1;
    #1;
    chk({tag, "_push_d0"}, push_d0, 0);
    chk({tag, "_push_d1"}, push_d1, 0);
    chk({tag, "_data"}, data_d0 | data_d1, 0);
    chk({tag, "_pops"}, pop_vc0 | pop_vc1, 0);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_cnts"}, cnt_d0 | cnt_d1, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    data_mux_0 = '0;
    data_mux_1 = '0;
    pause_pct = 0;
    model_reset();
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_pops", pop_vc0 | pop_vc1, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset mid-stream, then both VCs empty: stays idle.
    for (int i = 0; i < 10; i++) q0.push_back(DW'($urandom));
    for (int i = 0; i < 4; i++) cycle();
    reset_mid("t1");
    for (int i = 0; i < 5; i++) cycle();

    // VC0 only, three words with mixed destinations.
    q0.push_back(6'h01);
    q0.push_back(6'h22);
    q0.push_back(6'h05);
    for (int i = 0; i < 8; i++) cycle();
    chk("t2_cnt_d0", cnt_d0, 2);
    chk("t2_cnt_d1", cnt_d1, 1);

    // Fairness with both VCs backlogged.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DW'($urandom));
      q1.push_back(DW'($urandom));
    end
    for (int i = 0; i < 24; i++) cycle();

    // Random traffic with random pauses on either destination.
    pause_pct = 25;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 45 && q0.size() < 16) q0.push_back(DW'($urandom));
      if ($urandom_range(99) < 35 && q1.size() < 16) q1.push_back(DW'($urandom));
      cycle();
    end
    pause_pct = 0;

    // Async reset with a word in flight.
    for (int i = 0; i < 5; i++) q0.push_back(DW'($urandom));
    for (int i = 0; i < 3; i++) cycle();
    reset_mid("t5");
    cycle();
    chk("t5_cnt_d0", cnt_d0, 0);

    // Counter wrap: 257 words to D0.
    for (int i = 0; i < 257; i++) q0.push_back(DW'($urandom_range(31)));
    for (int i = 0; i < 262; i++) cycle();
    chk("t6_cnt_wrap", cnt_d0, 1);
    chk("t6_cnt_d1", cnt_d1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
